// File: rtl/tim_ctrl_pkg.sv
// Shared definitions for the TIM controller: register map, CTRL layout and FSM states.
package tim_ctrl_pkg;

    localparam int unsigned ADDR_CTRL = 32'h00;
    localparam int unsigned ADDR_PSC  = 32'h04;
    localparam int unsigned ADDR_ARR  = 32'h08;
    localparam int unsigned ADDR_CNT  = 32'h0C;
    localparam int unsigned ADDR_SR   = 32'h10;
    localparam int unsigned ADDR_EGR  = 32'h14;

    localparam int CTRL_CEN  = 0;
    localparam int CTRL_OPM  = 1;
    localparam int CTRL_ARPE = 2;
    localparam int CTRL_UIE  = 3;

    // Field order mirrors the CTRL bit positions, so the struct casts directly to/from the bus word.
    typedef struct packed {
        logic uie;
        logic arpe;
        logic opm;
        logic cen;
    } ctrl_t;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN
    } tim_state_t;

endpackage

// File: rtl/tim_ctrl_regs.sv
// Bus side of tim_ctrl: access handshake, address decode, CTRL fields,
// PSC/ARR preload and active copies, and the read-data mux.
module tim_ctrl_regs
    import tim_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int TIM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ready,
    input  logic [TIM_W-1:0]  tim_cnt,
    input  logic              uif,
    input  logic              load_active,
    input  logic              cen_clr,
    output logic              wr_ctrl,
    output logic              wr_cen,
    output logic              sr_clr,
    output logic              ug_wr,
    output ctrl_t             ctrl,
    output logic [TIM_W-1:0]  psc_act,
    output logic [TIM_W-1:0]  arr_act
);

    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TIM_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [TIM_W-1:0]  psc_sh_q, psc_sh_d, arr_sh_q, arr_sh_d;
    logic [TIM_W-1:0]  psc_act_q, psc_act_d, arr_act_q, arr_act_d;
    logic              wr_en, wr_psc, wr_arr;
    logic              unused_wdata_hi;

    // Writes commit on the edge closing the bus_ready cycle, from the request captured at acceptance.
    assign wr_en   = ready_q & we_q;
    assign wr_ctrl = wr_en & (addr_q == ADDR_W'(ADDR_CTRL));
    assign wr_psc  = wr_en & (addr_q == ADDR_W'(ADDR_PSC));
    assign wr_arr  = wr_en & (addr_q == ADDR_W'(ADDR_ARR));
    assign sr_clr  = wr_en & (addr_q == ADDR_W'(ADDR_SR))  & wdata_q[0];
    assign ug_wr   = wr_en & (addr_q == ADDR_W'(ADDR_EGR)) & wdata_q[0];
    assign wr_cen  = wdata_q[CTRL_CEN];
    assign unused_wdata_hi = ^bus_wdata[DATA_W-1:TIM_W];

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path can infer a latch.
        ready_d = bus_req & ~ready_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = '0;
        if (ready_d) begin
            we_d    = bus_we;
            addr_d  = bus_addr;
            wdata_d = bus_wdata[TIM_W-1:0];
            if (!bus_we) begin
                case (bus_addr)
                    ADDR_W'(ADDR_CTRL): rdata_d = DATA_W'(ctrl_q);
                    ADDR_W'(ADDR_PSC):  rdata_d = DATA_W'(psc_sh_q);
                    ADDR_W'(ADDR_ARR):  rdata_d = DATA_W'(arr_sh_q);
                    ADDR_W'(ADDR_CNT):  rdata_d = DATA_W'(tim_cnt);
                    ADDR_W'(ADDR_SR):   rdata_d = DATA_W'(uif);
                    default:            rdata_d = '0;
                endcase
            end
        end

        ctrl_d = ctrl_q;
        if (wr_ctrl) ctrl_d = ctrl_t'(wdata_q[$bits(ctrl_t)-1:0]);
        if (cen_clr) ctrl_d.cen = 1'b0;

        // Shadow is resolved first so a same-cycle reload picks up the value being written.
        psc_sh_d  = wr_psc ? wdata_q : psc_sh_q;
        arr_sh_d  = wr_arr ? wdata_q : arr_sh_q;
        psc_act_d = (load_active || (wr_psc && !ctrl_q.arpe)) ? psc_sh_d : psc_act_q;
        arr_act_d = (load_active || (wr_arr && !ctrl_q.arpe)) ? arr_sh_d : arr_act_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            ctrl_q    <= '0;
            psc_sh_q  <= '0;
            arr_sh_q  <= '0;
            psc_act_q <= '0;
            arr_act_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values together.
            ready_q   <= ready_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            ctrl_q    <= ctrl_d;
            psc_sh_q  <= psc_sh_d;
            arr_sh_q  <= arr_sh_d;
            psc_act_q <= psc_act_d;
            arr_act_q <= arr_act_d;
        end
    end

    assign bus_ready = ready_q;
    assign bus_rdata = rdata_q;
    assign ctrl      = ctrl_q;
    assign psc_act   = psc_act_q;
    assign arr_act   = arr_act_q;

endmodule

// File: rtl/tim_ctrl.sv
// TIM timer controller top: sequencing FSM, sticky overflow flag and interrupt,
// around the memory-mapped register block.
module tim_ctrl
    import tim_ctrl_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int TIM_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_ready,
    output logic              tim_en,
    output logic              tim_load,
    output logic [TIM_W-1:0]  tim_psc,
    output logic [TIM_W-1:0]  tim_arr,
    input  logic [TIM_W-1:0]  tim_cnt,
    input  logic              tim_done,
    output logic              irq
);

    tim_state_t state_q, state_d;
    logic       uif_q, uif_d, irq_q, irq_d, ug_q, ug_d;
    logic       wr_ctrl, wr_cen, sr_clr, ug_wr;
    ctrl_t      ctrl;
    logic       in_run, cen_rise, opm_stop, load_active;

    tim_ctrl_regs #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIM_W  (TIM_W)
    ) u_regs (
        .clk         (clk),
        .reset       (reset),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ready   (bus_ready),
        .tim_cnt     (tim_cnt),
        .uif         (uif_q),
        .load_active (load_active),
        .cen_clr     (opm_stop),
        .wr_ctrl     (wr_ctrl),
        .wr_cen      (wr_cen),
        .sr_clr      (sr_clr),
        .ug_wr       (ug_wr),
        .ctrl        (ctrl),
        .psc_act     (tim_psc),
        .arr_act     (tim_arr)
    );

    always_comb begin
        in_run      = (state_q == RUN);
        cen_rise    = wr_ctrl & wr_cen & ~ctrl.cen;
        opm_stop    = in_run & tim_done & ctrl.opm;
        ug_d        = ug_wr & (state_q != ARM);
        load_active = cen_rise | ug_d | (in_run & tim_done);

        state_d = state_q;
        case (state_q)
            IDLE:    if (cen_rise) state_d = ARM;
            ARM:     state_d = RUN;
            // Hardware one-pulse stop wins over any CTRL write landing on the same edge.
            RUN:     if (opm_stop || (wr_ctrl && !wr_cen)) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Overflow set takes priority over a coincident write-1-to-clear.
        uif_d = uif_q;
        if (sr_clr) uif_d = 1'b0;
        if (in_run && tim_done) uif_d = 1'b1;

        irq_d = uif_q & ctrl.uie;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            uif_q   <= 1'b0;
            irq_q   <= 1'b0;
            ug_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            uif_q   <= uif_d;
            irq_q   <= irq_d;
            ug_q    <= ug_d;
        end
    end

    assign tim_en   = (state_q == RUN);
    assign tim_load = (state_q == ARM) | ug_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_tim_ctrl.sv
// Scoreboard bench for tim_ctrl: directed scenarios plus randomized register traffic
// checked against a register-level reference model.
module tb_tim_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_req, bus_we;
    logic [4:0]  bus_addr;
    logic [31:0] bus_wdata, bus_rdata;
    logic        bus_ready;
    logic        tim_en, tim_load, tim_done, irq;
    logic [15:0] tim_psc, tim_arr, tim_cnt;

    tim_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ready (bus_ready),
        .tim_en    (tim_en),
        .tim_load  (tim_load),
        .tim_psc   (tim_psc),
        .tim_arr   (tim_arr),
        .tim_cnt   (tim_cnt),
        .tim_done  (tim_done),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int load_cnt = 0;

    typedef struct {
        bit          is_read;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: register-level view of the controller.
    bit          m_cen, m_opm, m_arpe, m_uie, m_uif;
    logic [15:0] m_psc_sh, m_arr_sh, m_psc, m_arr;
    int          m_loads;

    logic [4:0] rd_addrs [8] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    function automatic void model_reset();
        m_cen = 0; m_opm = 0; m_arpe = 0; m_uie = 0; m_uif = 0;
        m_psc_sh = 0; m_arr_sh = 0; m_psc = 0; m_arr = 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'h00:   return {28'h0, m_uie, m_arpe, m_opm, m_cen};
            5'h04:   return {16'h0, m_psc_sh};
            5'h08:   return {16'h0, m_arr_sh};
            5'h0C:   return {16'h0, tim_cnt};
            5'h10:   return {31'h0, m_uif};
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d);
        case (a)
            5'h00: begin
                if (!m_cen && d[0]) begin
                    m_psc = m_psc_sh; m_arr = m_arr_sh; m_loads++;
                end
                m_cen = d[0]; m_opm = d[1]; m_arpe = d[2]; m_uie = d[3];
            end
            5'h04: begin m_psc_sh = d[15:0]; if (!m_arpe) m_psc = d[15:0]; end
            5'h08: begin m_arr_sh = d[15:0]; if (!m_arpe) m_arr = d[15:0]; end
            5'h10: if (d[0]) m_uif = 0;
            5'h14: if (d[0]) begin m_psc = m_psc_sh; m_arr = m_arr_sh; m_loads++; end
            default: ;
        endcase
    endfunction

    function automatic void model_done();
        if (m_cen) begin
            m_uif = 1;
            m_psc = m_psc_sh;
            m_arr = m_arr_sh;
            if (m_opm) m_cen = 0;
        end
    endfunction

    // Monitor: every bus_ready pops the oldest expected response.
    always @(negedge clk) begin
        if (!reset && bus_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_ready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read)
                    check($sformatf("rdata[%02h]", mon_e.addr), bus_rdata, mon_e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && tim_load) load_cnt++;
    end

    // Returns at the negedge just after the write-commit edge, with bus_req held one cycle past ready.
    task automatic bus_op(input bit we, input logic [4:0] addr, input logic [31:0] data,
                          input bit done_at_commit);
        exp_t e;
        int   waited;
        @(negedge clk);
        bus_req = 1; bus_we = we; bus_addr = addr; bus_wdata = data;
        e.is_read = !we;
        e.addr    = addr;
        e.data    = we ? 32'h0 : model_read(addr);
        exp_q.push_back(e);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus_ready && waited < 8);
        check("ready_latency", 32'(waited), 32'd1);
        if (done_at_commit) tim_done = 1;
        @(negedge clk);
        check("ready_drop", 32'(bus_ready), 32'd0);
        bus_req = 0; tim_done = 0;
        if (we) model_write(addr, data);
        if (done_at_commit) model_done();
    endtask

    task automatic settle_check();
        repeat (2) @(negedge clk);
        check("tim_en",     32'(tim_en),   32'(m_cen));
        check("tim_psc",    32'(tim_psc),  32'(m_psc));
        check("tim_arr",    32'(tim_arr),  32'(m_arr));
        check("irq",        32'(irq),      32'(m_uif & m_uie));
        check("tim_load",   32'(tim_load), 32'd0);
        check("load_count", 32'(load_cnt), 32'(m_loads));
    endtask

    task automatic done_pulse();
        @(negedge clk) tim_done = 1;
        @(negedge clk) tim_done = 0;
        model_done();
        settle_check();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 32'(bus_ready), 32'd0);
        check({tag, "_rdata"}, bus_rdata,      32'd0);
        check({tag, "_en"},    32'(tim_en),    32'd0);
        check({tag, "_load"},  32'(tim_load),  32'd0);
        check({tag, "_psc"},   32'(tim_psc),   32'd0);
        check({tag, "_arr"},   32'(tim_arr),   32'd0);
        check({tag, "_irq"},   32'(irq),       32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; bus_req = 0; bus_we = 0; bus_addr = 0; bus_wdata = 0;
        tim_cnt = 16'h1234; tim_done = 0;
        model_reset();
        m_loads = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 0;

        // Reset-state readback of every register plus an unmapped address.
        for (int a = 0; a <= 'h18; a += 4) bus_op(0, 5'(a), 32'h0, 0);

        // ARPE=0 start-up, overflow and interrupt clear.
        bus_op(1, 5'h04, 32'd3, 0);
        bus_op(1, 5'h08, 32'd9, 0);
        settle_check();
        bus_op(1, 5'h00, 32'h9, 0);
        check("arm_load", 32'(tim_load), 32'd1);
        check("arm_en",   32'(tim_en),   32'd0);
        @(negedge clk);
        check("run_load", 32'(tim_load), 32'd0);
        check("run_en",   32'(tim_en),   32'd1);
        settle_check();
        @(negedge clk) tim_done = 1;
        @(negedge clk) tim_done = 0;
        check("irq_lag", 32'(irq), 32'd0);
        @(negedge clk);
        check("irq_rise", 32'(irq), 32'd1);
        model_done();
        settle_check();
        bus_op(0, 5'h10, 32'h0, 0);
        bus_op(1, 5'h10, 32'h1, 0);
        settle_check();

        // ARPE=1 while running: preload held until overflow or UG.
        bus_op(1, 5'h00, 32'hD, 0);
        bus_op(1, 5'h08, 32'd20, 0);
        settle_check();
        done_pulse();
        bus_op(1, 5'h08, 32'd30, 0);
        settle_check();
        bus_op(1, 5'h14, 32'h1, 0);
        settle_check();
        bus_op(0, 5'h10, 32'h0, 0);
        bus_op(0, 5'h08, 32'h0, 0);
        bus_op(0, 5'h14, 32'h0, 0);

        // One-pulse mode.
        bus_op(1, 5'h00, 32'h0, 0);
        bus_op(1, 5'h10, 32'h1, 0);
        settle_check();
        bus_op(1, 5'h00, 32'h3, 0);
        settle_check();
        @(negedge clk) tim_done = 1;
        @(negedge clk) tim_done = 0;
        check("opm_en_off", 32'(tim_en), 32'd0);
        model_done();
        settle_check();
        bus_op(0, 5'h00, 32'h0, 0);
        bus_op(0, 5'h10, 32'h0, 0);
        bus_op(1, 5'h10, 32'h1, 0);
        done_pulse();
        bus_op(0, 5'h10, 32'h0, 0);

        // Same-edge collisions.
        bus_op(1, 5'h00, 32'h1, 0);
        settle_check();
        done_pulse();
        bus_op(1, 5'h10, 32'h1, 1);
        settle_check();
        bus_op(0, 5'h10, 32'h0, 0);
        bus_op(1, 5'h00, 32'h5, 0);
        bus_op(1, 5'h08, 32'h77, 1);
        settle_check();
        bus_op(1, 5'h00, 32'h7, 0);
        bus_op(1, 5'h00, 32'h7, 1);
        settle_check();
        bus_op(0, 5'h00, 32'h0, 0);

        // Randomized register traffic.
        for (int i = 0; i < 120; i++) begin
            int unsigned op;
            op = $urandom_range(0, 6);
            tim_cnt = 16'($urandom());
            case (op)
                0: bus_op(1, 5'h04, $urandom(), 0);
                1: bus_op(1, 5'h08, $urandom(), 0);
                2: bus_op(1, 5'h00, $urandom(), 0);
                3: bus_op(0, rd_addrs[$urandom_range(0, 7)], 32'h0, 0);
                4: begin @(negedge clk) tim_done = 1; @(negedge clk) tim_done = 0; model_done(); end
                5: bus_op(1, 5'h10, $urandom(), 0);
                default: bus_op(1, 5'h14, $urandom(), 0);
            endcase
            settle_check();
        end

        // Reset while running with a request pending.
        bus_op(1, 5'h00, 32'h0, 0);
        bus_op(1, 5'h04, 32'h55, 0);
        bus_op(1, 5'h00, 32'h9, 0);
        settle_check();
        done_pulse();
        @(negedge clk);
        reset = 1; bus_req = 1; bus_we = 0; bus_addr = 5'h0C;
        @(negedge clk);
        check_all_zero("midreset");
        @(negedge clk);
        check("midreset_ready2", 32'(bus_ready), 32'd0);
        bus_req = 0; reset = 0;
        model_reset();
        settle_check();
        bus_op(0, 5'h04, 32'h0, 0);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tim_ctrl.md
Name: tim_ctrl

Overview:
- Memory-mapped controller that configures and sequences the TIM timer unit on behalf of the core datapath.
- The core writes and reads the timer registers through a load/store handshake.
- tim_ctrl owns the active and preload (shadow) PSC/ARR values, gates the timer enable, latches overflow events into a sticky flag and drives a level interrupt to the core.

Parameters:
- ADDR_W, 5, register byte-address width.
- DATA_W, 32, bus data width.
- TIM_W, 16, timer PSC/ARR/CNT width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- bus_req  in  1  access request from datapath; held until bus_ready.
- bus_we  in  1  1=write, 0=read; stable while bus_req.
- bus_addr  in  ADDR_W  register byte address (word aligned).
- bus_wdata  in  DATA_W  write data.
- bus_rdata  out  DATA_W  read data; valid when bus_ready.
- bus_ready  out  1  one-cycle access completion.
- tim_en  out  1  timer count enable.
- tim_load  out  1  one-cycle pulse: timer clears CNT and prescaler, samples tim_psc/tim_arr.
- tim_psc  out  TIM_W  active prescaler value.
- tim_arr  out  TIM_W  active auto-reload value.
- tim_cnt  in  TIM_W  live timer count.
- tim_done  in  1  one-cycle overflow pulse from the timer.
- irq  out  1  timer interrupt, level.

Behaviour:
- Register map:
  - 0x00 CTRL: [0] CEN, [1] OPM one-pulse, [2] ARPE preload enable, [3] UIE.
  - 0x04 PSC: rw, shadow.
  - 0x08 ARR: rw, shadow.
  - 0x0C CNT: ro, returns tim_cnt zero-extended.
  - 0x10 SR: [0] UIF, write-1-to-clear.
  - 0x14 EGR: [0] UG, write-only, reads 0.
- Unmapped addresses read 0, writes are ignored, and bus_ready is still returned. Bits above each field width read 0.
- Handshake:
  - bus_req is sampled at cycle N; bus_ready=1 and bus_rdata valid at N+1. The register write takes effect at the N+1 edge.
  - bus_ready is deasserted at N+2 even if bus_req is still high.
  - A new access is accepted only after the cycle following bus_ready. Max one access per 2 cycles.
- Shadows:
  - ARPE=0: writing PSC/ARR updates both shadow and active values. tim_psc/tim_arr change the cycle after bus_ready.
  - ARPE=1: writing updates only the shadow. Active takes the shadow on tim_done or UG.
- FSM states and transitions:
  - IDLE → ARM: on CEN 0→1 write. Active takes the shadow.
  - ARM (1 cycle): tim_load=1, tim_en=0. Then → RUN.
  - RUN: tim_en=1. CEN write 0 → IDLE next cycle, tim_en=0 (CNT held, not cleared).
  - RUN with tim_done & OPM: hardware clears CEN → IDLE, tim_en=0 next cycle.
  - UG in IDLE or RUN: active takes the shadow and tim_load pulses for 1 cycle. UIF is not set. In RUN, tim_en stays 1.
- UIF and irq:
  - tim_done in RUN sets UIF.
  - A W1C write and tim_done in the same cycle: set wins, UIF=1.
  - irq = UIF & UIE, registered, so it rises 1 cycle after UIF.
  - tim_done outside RUN is ignored.
- Simultaneous events:
  - tim_done together with a PSC/ARR write under ARPE=1: the shadow is updated first. Active takes the new value.
  - tim_done & OPM together with a CEN=1 write: OPM stop wins. CEN=0, state IDLE.
- Reset: all registers 0, state IDLE, bus_ready=0, bus_rdata=0, tim_en=0, tim_load=0, tim_psc=0, tim_arr=0, irq=0. Reset mid-access drops the access with no bus_ready.

Decomposition:
- Package tim_ctrl_pkg:
  - Register address localparams: ADDR_CTRL, ADDR_PSC, ADDR_ARR, ADDR_CNT, ADDR_SR, ADDR_EGR.
  - CTRL bit index constants.
  - Enum tim_state_t {IDLE, ARM, RUN}.
- One natural sub-module: tim_ctrl_regs (bus decode, shadow/active registers, rdata mux). The FSM and UIF logic stay in tim_ctrl.

Test Plan:
- Reset, then read each address → CTRL/PSC/ARR/SR/EGR=0, CNT=tim_cnt, 0x18 → 0, bus_ready 1 cycle after each req.
- ARPE=0: write PSC=3, ARR=9, CTRL=0x9 → tim_psc=3, tim_arr=9, one tim_load pulse, tim_en=1. Inject tim_done → UIF=1, irq=1 next cycle. Write SR=1 → irq=0.
- ARPE=1 in RUN: write ARR=20 → tim_arr stays 9 until tim_done, then 20. Write ARR=30 and EGR=1 → tim_arr=30, tim_load pulse, UIF unchanged.
- OPM: CTRL=0x3, one tim_done → CEN reads 0, tim_en=0 next cycle, UIF=1. A second tim_done is ignored.
- W1C write to SR coincident with tim_done → UIF remains 1. With UIE=0 → irq stays 0.
- Assert reset during RUN with a bus_req pending → no bus_ready, all outputs 0 next cycle.
